// File: rtl/wdt_pkg.sv
// Watchdog controller shared types.
// State encoding and default kick key.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WARN = 2'd2,
    ST_BITE = 2'd3
  } wdt_state_e;

  localparam logic [15:0] WDT_KEY = 16'hA55A;

endpackage

// File: rtl/wdt_counter.sv
// Watchdog up-counter.
// Clear wins over enable; holds otherwise.
module wdt_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: config lock, keyed
// windowed kick, warn and bite thresholds.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int          CNT_W = 32,
  parameter logic [15:0] KEY   = WDT_KEY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_win,
  input  logic [CNT_W-1:0] cfg_warn,
  input  logic [CNT_W-1:0] cfg_bite,
  input  logic             kick,
  input  logic [15:0]      kick_key,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt,
  output logic             warn_irq,
  output logic             bite,
  output logic             kick_err,
  output logic             cfg_err
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] win_q, warn_q, bite_q;
  logic             kerr_d, cerr_d;
  logic             cfg_load, cnt_clr, cnt_en;
  logic             cfg_fire, cfg_legal;
  logic             key_ok, kick_ok, kick_win, kick_bad;

  assign cfg_ready = (state_q == ST_DIS);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_legal = (cfg_win <= cfg_warn) &&
                     (cfg_warn < cfg_bite) &&
                     (cfg_bite != '0);

  assign key_ok   = kick && (kick_key == KEY);
  assign kick_ok  = key_ok && (cnt >= win_q);
  assign kick_win = key_ok && (cnt < win_q);
  assign kick_bad = kick && (kick_key != KEY);

  assign state    = state_q;
  assign warn_irq = (state_q == ST_WARN);
  assign bite     = (state_q == ST_BITE);

  wdt_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (cnt)
  );

  // next state, counter control and error pulses
  always_comb begin
    state_d  = state_q;
    kerr_d   = 1'b0;
    cerr_d   = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_DIS: begin
        if (cfg_fire) begin
          if (cfg_legal) begin
            cfg_load = 1'b1;
            if (cfg_en) begin
              state_d = ST_RUN;
              cnt_clr = 1'b1;
            end
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      ST_RUN, ST_WARN: begin
        unique case (1'b1)
          kick_ok: begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
          kick_win: begin
            kerr_d  = 1'b1;
            state_d = ST_BITE;
          end
          default: begin
            kerr_d = kick_bad;
            if (cnt == bite_q) begin
              state_d = ST_BITE;
            end else begin
              cnt_en = 1'b1;
              if (state_q == ST_RUN && cnt == warn_q)
                state_d = ST_WARN;
            end
          end
        endcase
      end
      ST_BITE: begin
        state_d = ST_BITE;
      end
    endcase
  end

  // state, thresholds and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DIS;
      win_q    <= '0;
      warn_q   <= '0;
      bite_q   <= '0;
      kick_err <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kick_err <= kerr_d;
      cfg_err  <= cerr_d;
      if (cfg_load) begin
        win_q  <= cfg_win;
        warn_q <= cfg_warn;
        bite_q <= cfg_bite;
      end
    end
  end

endmodule

// File: doc/wdt_ctrl.md
WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, counter and threshold width.
REQ-002 Parameter: KEY, default 16'hA55A, kick key value.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_valid  in  1  configuration request.
REQ-006 cfg_ready  out  1  high only in DISABLED; transfer = cfg_valid & cfg_ready.
REQ-007 cfg_en  in  1  start watchdog on accepted config.
REQ-008 cfg_win / cfg_warn / cfg_bite  in  CNT_W each  window-open, warning and bite thresholds.
REQ-009 kick  in  1  single-cycle service strobe.
REQ-010 kick_key  in  16  key qualifying kick.
REQ-011 state  out  2  DISABLED=0, RUN=1, WARN=2, BITE=3.
REQ-012 cnt  out  CNT_W  current count.
REQ-013 warn_irq  out  1  level, high while state==WARN.
REQ-014 bite  out  1  reset request, high while state==BITE.
REQ-015 kick_err / cfg_err  out  1 each  single-cycle error pulses.

Function
REQ-016 Config is legal iff cfg_win <= cfg_warn, cfg_warn < cfg_bite, and cfg_bite != 0.
REQ-017 Accepted legal config with cfg_en=1 latches all thresholds, clears cnt and enters RUN the next cycle.
REQ-018 Accepted legal config with cfg_en=0 latches thresholds and stays in DISABLED.
REQ-019 Accepted illegal config pulses cfg_err one cycle after acceptance, latches nothing and stays in DISABLED.
REQ-020 Once out of DISABLED, config is locked: cfg_ready=0 and cfg_valid is ignored until reset.
REQ-021 In RUN and WARN, cnt increments by 1 per cycle; it is held in DISABLED and frozen in BITE.
REQ-022 Valid kick: kick=1, kick_key==KEY and cnt >= latched cfg_win.
REQ-023 Valid kick in RUN or WARN sets cnt to 0 and makes state RUN next cycle; warn_irq deasserts that same cycle.
REQ-024 kick=1 with a wrong key in RUN or WARN pulses kick_err next cycle and is otherwise ignored.
REQ-025 kick=1 with the correct key while cnt < cfg_win is a window violation: it pulses kick_err and makes state BITE next cycle.
REQ-026 In RUN, cnt == cfg_warn with no kick makes state WARN next cycle.
REQ-027 In RUN or WARN, cnt == cfg_bite with no kick makes state BITE next cycle.
REQ-028 Same-cycle priority: valid kick > window violation > bite threshold > warn threshold.
REQ-029 BITE is terminal until rst_n: bite=1, warn_irq=0, and kick is ignored with no kick_err.
REQ-030 kick in DISABLED is ignored with no kick_err.
REQ-031 Outputs are registered; every event takes effect one cycle after the sampling edge.

Reset
REQ-032 rst_n low immediately forces state=DISABLED, cnt=0, all thresholds=0, warn_irq=0, bite=0, kick_err=0, cfg_err=0, cfg_ready=1.
REQ-033 Reset asserted mid-operation, including in BITE, discards all state and releases the config lock.

Structure
REQ-034 Package wdt_pkg holds the state encoding enum and the default KEY constant.
REQ-035 One sub-module, wdt_counter, provides an enabled, clearable CNT_W counter; the FSM and the compare logic stay in wdt_ctrl.

Verification
REQ-036 Config win=2, warn=5, bite=8, en=1; no kicks -> WARN at cnt==6 output, BITE at cnt==8 output, bite stays high for 20 further cycles.
REQ-037 Same config; valid kick at cnt=4 -> cnt=0 next cycle, state RUN, no kick_err.
REQ-038 Same config; key 16'h1234 at cnt=3 -> kick_err one-cycle pulse, counting continues; correct key at cnt=1 -> kick_err and BITE.
REQ-039 Valid kick in the same cycle as cnt==8 -> RUN with cnt 0; not BITE.
REQ-040 Config warn=8, bite=8 -> cfg_err pulse, state stays DISABLED; then a legal config is accepted; a second cfg_valid while in RUN -> cfg_ready=0 and thresholds unchanged.
REQ-041 rst_n low asynchronously in WARN -> state, cnt and warn_irq clear without a clock edge; cfg_ready=1.
